// File: rtl/imm_ext_pipe_pkg.sv
// Shared mode encoding for the pipelined immediate extender.
package imm_ext_pipe_pkg;

  typedef logic [2:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN      = 3'b000;
  localparam ext_mode_t EXT_ZERO      = 3'b001;
  localparam ext_mode_t EXT_HIGH      = 3'b010;
  localparam ext_mode_t EXT_SIGN_SHL  = 3'b011;
  localparam ext_mode_t EXT_ZERO_SHL  = 3'b100;
  localparam ext_mode_t EXT_SIGN_HALF = 3'b101;
  localparam ext_mode_t EXT_ZERO_HALF = 3'b110;
  localparam ext_mode_t EXT_RSVD      = 3'b111;

endpackage

// File: rtl/imm_ext_pipe_core.sv
// Combinational mode -> extended data / illegal-mode flag.
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  localparam int H = IN_W / 2;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mode)
      EXT_SIGN:      data = sext;
      EXT_ZERO:      data = zext;
      EXT_HIGH:      data = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_SIGN_SHL:  data = sext << SHIFT;
      EXT_ZERO_SHL:  data = zext << SHIFT;
      EXT_SIGN_HALF: data = {{(OUT_W-H){imm[H-1]}}, imm[H-1:0]};
      EXT_ZERO_HALF: data = {{(OUT_W-H){1'b0}}, imm[H-1:0]};
      default:       err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry output skid buffer.
// Optional accept/illegal counters when EXT_STATS_EN is defined.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  ext_mode_t        in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef EXT_STATS_EN
  ,
  output logic [31:0]      stat_acc,
  output logic [31:0]      stat_err
`endif
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t     head_q, tail_q, new_e;
  logic [1:0] count;
  logic       acc, pop;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (new_e.data),
    .err  (new_e.err)
  );
  assign new_e.tag = in_tag;

  // Handshake: a transfer happens on a cycle where valid && ready on the same
  // side; in_ready depends on count only, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({acc, pop})
        2'b10: begin
          if (count == 2'd0) head_q <= new_e;
          else               tail_q <= new_e;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          tail_q <= '0;
          count  <= count - 2'd1;
        end
        // Accept and pop together only happens at count 1: new op becomes head.
        2'b11:   head_q <= new_e;
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? head_q.data : '0;
  assign out_tag  = out_valid ? head_q.tag  : '0;
  assign out_err  = out_valid ? head_q.err  : 1'b0;

`ifdef EXT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_acc <= 32'd0;
      stat_err <= 32'd0;
    end else if (acc) begin
      stat_acc <= stat_acc + 32'd1;
      if (new_e.err) stat_err <= stat_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: mode table, stall/skid sequence, streaming,
// reset while full, and randomized valid/ready against a reference model.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SHIFT = 2;
  localparam int TAG_W = 5;
  localparam int W     = OUT_W + TAG_W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [2:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
`ifdef EXT_STATS_EN
  logic [31:0]      stat_acc;
  logic [31:0]      stat_err;
`endif

  imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
`ifdef EXT_STATS_EN
    ,
    .stat_acc  (stat_acc),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic last_acc;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic on integers, result taken modulo 2^32.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    longint u, s, lo, ls, r;
    u  = longint'(imm);
    s  = (u >= 32768) ? u - 65536 : u;
    lo = u % 256;
    ls = (lo >= 128) ? lo - 256 : lo;
    case (mode)
      3'd0:    r = s;
      3'd1:    r = u;
      3'd2:    r = u * 65536;
      3'd3:    r = s * (64'sd1 <<< SHIFT);
      3'd4:    r = u * (64'sd1 <<< SHIFT);
      3'd5:    r = ls;
      3'd6:    r = lo;
      default: r = 0;
    endcase
    return r[OUT_W-1:0];
  endfunction

  // One cycle: drive at negedge, then record the handshakes the next posedge will see.
  task automatic step(input logic v, input logic [IN_W-1:0] imm, input logic [2:0] mode,
                      input logic [TAG_W-1:0] tag, input logic rdy);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = rdy;
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back({ref_ext(imm, mode), tag, (mode == 3'b111)});
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_data, out_tag, out_err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(out_data), 64'(e[W-1:TAG_W+1]));
        check("sb_tag",  64'(out_tag),  64'(e[TAG_W:1]));
        check("sb_err",  64'(out_err),  64'(e[0]));
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
  endtask

  typedef struct {
    logic [IN_W-1:0]  imm;
    logic [2:0]       mode;
    logic [OUT_W-1:0] data;
    logic             err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [OUT_W-1:0] held;
    int sent, cyc, pops0;
    logic pend;
    logic [IN_W-1:0] r_imm;
    logic [2:0] r_mode;

    vecs[0] = '{16'h8001, 3'b000, 32'hFFFF8001, 1'b0};
    vecs[1] = '{16'h8001, 3'b001, 32'h00008001, 1'b0};
    vecs[2] = '{16'h8001, 3'b010, 32'h80010000, 1'b0};
    vecs[3] = '{16'h8001, 3'b011, 32'hFFFE0004, 1'b0};
    vecs[4] = '{16'h8001, 3'b100, 32'h00020004, 1'b0};
    vecs[5] = '{16'h8001, 3'b101, 32'h00000001, 1'b0};
    vecs[6] = '{16'h8001, 3'b110, 32'h00000001, 1'b0};
    vecs[7] = '{16'h1234, 3'b111, 32'h00000000, 1'b1};

    do_reset(3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // Mode table: each result must be visible exactly one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].imm, vecs[i].mode, 5'(i + 1), 1'b1);
      check("tbl_accept", 64'(last_acc), 64'd1);
      step(1'b0, '0, '0, '0, 1'b1);
      check("tbl_valid", 64'(out_valid), 64'd1);
      check("tbl_data",  64'(out_data),  64'(vecs[i].data));
      check("tbl_err",   64'(out_err),   64'(vecs[i].err));
      check("tbl_tag",   64'(out_tag),   64'(i + 1));
    end
    step(1'b0, '0, '0, '0, 1'b1);
    check("tbl_drained", 64'(out_valid), 64'd0);
`ifdef EXT_STATS_EN
    check("stat_err_one", 64'(stat_err), 64'd1);
    check("stat_acc_tbl", 64'(stat_acc), 64'd8);
`endif

    // Stall: out_ready low, push tags 1,2,3.
    step(1'b1, 16'h00F0, 3'b000, 5'd1, 1'b0);
    check("stall_acc1", 64'(last_acc), 64'd1);
    step(1'b1, 16'h0F00, 3'b001, 5'd2, 1'b0);
    check("stall_acc2", 64'(last_acc), 64'd1);
    step(1'b1, 16'hF000, 3'b010, 5'd3, 1'b0);
    check("stall_full_ready", 64'(in_ready), 64'd0);
    check("stall_no_acc3", 64'(last_acc), 64'd0);
    held = out_data;
    check("stall_head_data", 64'(held), 64'(ref_ext(16'h00F0, 3'b000)));
    step(1'b1, 16'hF000, 3'b010, 5'd3, 1'b0);
    check("stall_stable_data", 64'(out_data), 64'(held));
    check("stall_stable_tag",  64'(out_tag),  64'd1);
    step(1'b1, 16'hF000, 3'b010, 5'd3, 1'b1);
    check("stall_pop_no_acc", 64'(last_acc), 64'd0);
    step(1'b1, 16'hF000, 3'b010, 5'd3, 1'b0);
    check("stall_acc3", 64'(last_acc), 64'd1);
    check("stall_head2", 64'(out_tag), 64'd2);
    repeat (4) step(1'b0, '0, '0, '0, 1'b1);
    check("stall_empty", 64'(exp_q.size()), 64'd0);

    // Streaming 100 back-to-back ops.
    do_reset(1);
    pops0 = pops;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), 5'(i), 1'b1);
      if (!last_acc) check("stream_acc", 64'(last_acc), 64'd1);
      if (i > 0 && !out_valid) check("stream_valid", 64'(out_valid), 64'd1);
    end
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    check("stream_pops", 64'(pops - pops0), 64'd100);
`ifdef EXT_STATS_EN
    check("stat_acc_100", 64'(stat_acc), 64'd100);
`endif

    // Reset while full.
    step(1'b1, 16'h1111, 3'b001, 5'd7, 1'b0);
    step(1'b1, 16'h2222, 3'b001, 5'd8, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    do_reset(1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data",  64'(out_data),  64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd1);
    repeat (4) step(1'b0, '0, '0, '0, 1'b1);
    check("no_stale", 64'(out_valid), 64'd0);

    // Random valid/ready over 1000 ops; producer holds an op until accepted.
    pops0 = pops; sent = 0; cyc = 0; pend = 1'b0; r_imm = '0; r_mode = '0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; r_imm = 16'($urandom); r_mode = 3'($urandom_range(0, 7));
      end
      step(pend, r_imm, r_mode, 5'(sent), ($urandom_range(0, 3) != 0));
      if (last_acc) begin sent++; pend = 1'b0; end
      cyc++;
    end
    check("rand_sent",  64'(sent), 64'd1000);
    check("rand_pops",  64'(pops - pops0), 64'd1000);
    check("rand_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
